// File: rtl/adc_wr_arbiter.sv
// adc_wr_arbiter: round-robin arbiter sharing one registered memory write port between two ADC capture channels
module adc_wr_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_chip_select_n,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest_n,
  input  logic              b_chip_select_n,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest_n,
  output logic              master_chip_select_n,
  output logic [ADDR_W:0]   master_addr,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic              master_waitrequest_n,
  input  logic              clr_counts,
  output logic [CNT_W-1:0]  wr_count_a,
  output logic [CNT_W-1:0]  wr_count_b
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;
  logic last_grant, req_a, req_b, can_take, grant_a, grant_b;
  assign req_a = ~a_chip_select_n & a_write;
  assign req_b = ~b_chip_select_n & b_write;
  // Grant the channel that did not win last time when both ask; accept only when the output stage frees up
  always_comb begin
    can_take = ~reset & ((state == IDLE) | master_waitrequest_n);
    grant_a = req_a & (~req_b | last_grant);
    grant_b = req_b & ~grant_a;
    a_waitrequest_n = can_take & grant_a;
    b_waitrequest_n = can_take & grant_b;
    state_nxt = can_take ? ((req_a | req_b) ? ISSUE : IDLE) : state;
    master_chip_select_n = state != ISSUE;
    master_write = state == ISSUE;
  end
  // Output command stage: capture the winner with its channel id in the address MSB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      master_addr <= '0;
      master_writedata <= '0;
    end else begin
      state <= state_nxt;
      if (a_waitrequest_n | b_waitrequest_n) begin
        last_grant <= grant_b;
        master_addr <= {grant_b, grant_b ? b_addr : a_addr};
        master_writedata <= grant_b ? b_writedata : a_writedata;
      end
    end
  end
  // Per-channel counts of writes accepted from the requesters; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_a <= '0;
      wr_count_b <= '0;
    end else begin
      wr_count_a <= clr_counts ? '0 : wr_count_a + CNT_W'(a_waitrequest_n);
      wr_count_b <= clr_counts ? '0 : wr_count_b + CNT_W'(b_waitrequest_n);
    end
  end
endmodule
